// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and helpers for the tpu_mv_core matrix-vector engine.
//   cmd_e    - command codes carried on uio_in[1:0]
//   state_e  - controller states
//   uio bit positions for the control/status byte
//   sat8     - clamp a signed value to int8
package tpu_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_LOAD_W = 2'd1,
    CMD_LOAD_X = 2'd2,
    CMD_RUN    = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_COMPUTE,
    S_DRAIN
  } state_e;

  localparam int CMD_LSB       = 0;
  localparam int IN_VALID_BIT  = 2;
  localparam int OUT_READY_BIT = 3;
  localparam int OUT_VALID_BIT = 6;
  localparam int BUSY_BIT      = 7;

  // Accumulators are at most 32 bits wide, so callers sign-extend into this.
  function automatic logic [7:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127)       return 8'h7F;
    else if (v < -32'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

endpackage

// File: rtl/tpu_mac_lane.sv
// tpu_mac_lane: one signed int8 x int8 multiply-accumulate lane.
//   clk, rst_n : clock, async active-low reset
//   en         : advance the accumulator this cycle
//   clear      : load the product instead of adding it (first term of a dot product)
//   w, x       : int8 operands
//   acc        : registered accumulator
//   acc_nxt    : value acc takes on the next enabled edge, so the owner can
//                capture the finished sum on the same edge as the last term
module tpu_mac_lane #(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic signed [7:0]       w,
  input  logic signed [7:0]       x,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] acc_nxt
);

  logic signed [15:0] prod;

  // Full int8*int8 product always fits in 16 signed bits.
  assign prod    = 16'(w) * 16'(x);
  assign acc_nxt = clear ? ACC_W'(prod) : acc + ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc <= '0;
    else if (en) acc <= acc_nxt;
  end

endmodule

// File: rtl/tpu_mv_core.sv
// tpu_mv_core: byte-serial int8 matrix-vector engine (y = sat8((W*x) >>> SHIFT)).
//   clk, rst_n : clock, async active-low reset
//   ena        : global enable, freezes every register when low
//   ui_in      : data byte (int8)
//   uio_in     : [1:0] cmd, [2] in_valid, [3] out_ready
//   uo_out     : result byte, 0 whenever out_valid is low
//   uio_out    : [7] busy, [6] out_valid
//   uio_oe     : constant 8'b1100_0000
// One counter pair (r_q, c_q) serves all phases: row/col while loading W,
// element index while loading x, term index k in COMPUTE, byte index j in DRAIN.
module tpu_mv_core
  import tpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 20,
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e state_q, state_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;

  logic [N-1:0][N-1:0][7:0] w_q;
  logic [N-1:0][7:0]        x_q;
  logic [N-1:0][7:0]        y_q;
  logic [N-1:0][7:0]        y_nxt;
  logic [N-1:0][ACC_W-1:0]  lane_acc;

  logic we_w, we_x, cap_y, comp;
  logic in_valid, out_ready, last_c, last_r;
  logic busy, out_valid;
  cmd_e cmd;

  assign cmd       = cmd_e'(uio_in[CMD_LSB +: 2]);
  assign in_valid  = uio_in[IN_VALID_BIT];
  assign out_ready = uio_in[OUT_READY_BIT];
  assign last_c    = (c_q == CW'(N-1));
  assign last_r    = (r_q == CW'(N-1));

  // Next-state / control
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    we_w    = 1'b0;
    we_x    = 1'b0;
    cap_y   = 1'b0;
    comp    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (cmd)
            CMD_LOAD_W: state_d = S_LOAD_W;
            CMD_LOAD_X: state_d = S_LOAD_X;
            CMD_RUN:    state_d = S_COMPUTE;
            default:    state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD_W: begin
        if (in_valid) begin
          we_w = 1'b1;
          if (last_c) begin
            c_d = '0;
            if (last_r) begin
              r_d     = '0;
              state_d = S_IDLE;
            end else begin
              r_d = r_q + CW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      S_LOAD_X: begin
        if (in_valid) begin
          we_x = 1'b1;
          if (last_c) begin
            c_d     = '0;
            state_d = S_IDLE;
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        comp = 1'b1;
        if (last_c) begin
          // Last term lands in the lanes on this edge; capture via acc_nxt.
          c_d     = '0;
          cap_y   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (last_c) begin
            c_d     = '0;
            state_d = S_IDLE;
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      w_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (ena) begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      if (we_w)  w_q[r_q][c_q] <= ui_in;
      if (we_x)  x_q[c_q]      <= ui_in;
      if (cap_y) y_q           <= y_nxt;
    end
  end

  // MAC lanes: lane i walks row i of W against x, one term per COMPUTE cycle.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [ACC_W-1:0] acc_n, acc_sh;

    tpu_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ena & comp),
      .clear   (c_q == '0),
      .w       (w_q[i][c_q]),
      .x       (x_q[c_q]),
      .acc     (lane_acc[i]),
      .acc_nxt (acc_n)
    );

    assign acc_sh   = acc_n >>> SHIFT;
    assign y_nxt[i] = sat8(32'(acc_sh));
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DRAIN);
  assign uo_out    = out_valid ? y_q[c_q] : 8'h00;
  assign uio_oe    = 8'b1100_0000;

  always_comb begin
    uio_out                = '0;
    uio_out[BUSY_BIT]      = busy;
    uio_out[OUT_VALID_BIT] = out_valid;
  end

  // Registered accumulators and the spare uio_in bits are not needed here.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:4], lane_acc};

endmodule

// File: tb/tb_tpu_mv_core.sv
module tb_tpu_mv_core;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo0, uio_out0, oe0;
  logic [7:0] uo1, uio_out1, oe1;

  tpu_mv_core #(.N(N), .ACC_W(20), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo0), .uio_out(uio_out0), .uio_oe(oe0));

  tpu_mv_core #(.N(N), .ACC_W(20), .SHIFT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio_out1), .uio_oe(oe1));

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int mw[N][N];
  int mx[N];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic iv, input logic rdy, input logic [7:0] d);
    uio_in = {4'b0000, rdy, iv, cmd};
    ui_in  = d;
  endtask

  // Reference: plain dot product, arithmetic shift, clamp to int8.
  function automatic int ref_y(input int i, input int sh);
    int s = 0;
    for (int k = 0; k < N; k++) s += mw[i][k] * mx[k];
    s = s >>> sh;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s & 255;
  endfunction

  function automatic int s8(input int v);
    logic [7:0] b;
    b = 8'(v);
    return int'($signed(b));
  endfunction

  task automatic send_w(input bit gaps);
    drive(2'd1, 1'b1, 1'b0, 8'hA5);
    tick();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (gaps)
          while ($urandom_range(0, 2) == 0) begin
            drive(2'd0, 1'b0, 1'b0, 8'($urandom));
            tick();
          end
        drive(2'($urandom), 1'b1, 1'b0, 8'(mw[r][c]));
        tick();
      end
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    chk("load_w_done_idle", int'(uio_out0[7]), 0);
  endtask

  task automatic send_x(input bit gaps);
    drive(2'd2, 1'b1, 1'b0, 8'h5A);
    tick();
    for (int c = 0; c < N; c++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          drive(2'd0, 1'b0, 1'b0, 8'($urandom));
          tick();
        end
      drive(2'($urandom), 1'b1, 1'b0, 8'(mx[c]));
      tick();
    end
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    chk("load_x_done_idle", int'(uio_out0[7]), 0);
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random ready.
  task automatic run_drain(input int mode, input bit stall_ena, input bit check_lat, input bit inject_ldx);
    int t, got, cyc;
    bit rdy, stalled_done;
    drive(2'd3, 1'b1, 1'b0, 8'h00);
    tick();
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    chk("run_busy", int'(uio_out0[7]), 1);
    t = 0;
    while (!uio_out0[6] && t < 40) begin
      chk("compute_uo_zero", int'(uo0), 0);
      if (inject_ldx && t == 1) drive(2'd2, 1'b1, 1'b0, 8'h55);
      else                      drive(2'd0, 1'b0, 1'b0, 8'h00);
      tick();
      t++;
    end
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    chk("valid_seen", int'(uio_out0[6]), 1);
    if (check_lat) chk("valid_latency", t, N);
    got = 0;
    cyc = 0;
    stalled_done = 0;
    while (got < N && cyc < 60) begin
      chk("drain_valid", int'(uio_out0[6]), 1);
      chk("y_shift0", int'(uo0), ref_y(got, 0));
      chk("y_shift8", int'(uo1), ref_y(got, 8));
      if (stall_ena && got == 1 && !stalled_done) begin
        ena = 1'b0;
        drive(2'd0, 1'b0, 1'b1, 8'h00);
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("ena_hold_valid", int'(uio_out0[6]), 1);
          chk("ena_hold_y", int'(uo0), ref_y(got, 0));
        end
        ena = 1'b1;
        stalled_done = 1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      drive(2'd0, 1'b0, rdy, 8'h00);
      tick();
      if (rdy) got++;
      cyc++;
    end
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    chk("drain_count", got, N);
    if (check_lat) chk("drain_cycles", cyc, N);
    chk("after_valid", int'(uio_out0[6]), 0);
    chk("after_busy", int'(uio_out0[7]), 0);
    chk("after_uo", int'(uo0), 0);
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++) begin
      mx[r] = 0;
      for (int c = 0; c < N; c++) mw[r][c] = 0;
    end
  endtask

  initial begin
    clear_model();
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    #12;
    chk("rst_uo", int'(uo0), 0);
    chk("rst_uio_out", int'(uio_out0), 0);
    chk("rst_oe", int'(oe0), 8'hC0);
    chk("rst_uo_s8", int'(uo1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // RUN straight after reset uses zero W/x
    run_drain(0, 0, 0, 0);

    // identity
    for (int r = 0; r < N; r++) begin
      mx[r] = r + 1;
      for (int c = 0; c < N; c++) mw[r][c] = (r == c) ? 1 : 0;
    end
    send_w(0);
    send_x(0);
    run_drain(0, 0, 1, 0);

    // saturation both directions, and shifted variants
    for (int r = 0; r < N; r++) begin
      mx[r] = 127;
      for (int c = 0; c < N; c++) mw[r][c] = 127;
    end
    send_w(0);
    send_x(0);
    run_drain(0, 0, 0, 0);
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = -128;
    send_w(0);
    run_drain(0, 0, 0, 0);
    for (int r = 0; r < N; r++) begin
      mx[r] = 100;
      for (int c = 0; c < N; c++) mw[r][c] = 1;
    end
    send_w(0);
    send_x(0);
    run_drain(0, 0, 0, 0);

    // random data loaded with gaps, backpressure, repeated runs, ignored LOAD_X
    for (int r = 0; r < N; r++) begin
      mx[r] = s8($urandom);
      for (int c = 0; c < N; c++) mw[r][c] = s8($urandom);
    end
    send_w(1);
    send_x(1);
    run_drain(1, 0, 0, 1);
    run_drain(2, 0, 0, 0);
    run_drain(0, 1, 0, 0);

    // async reset mid-COMPUTE
    drive(2'd3, 1'b1, 1'b0, 8'h00);
    tick();
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_compute_uio", int'(uio_out0), 0);
    chk("rst_compute_uo", int'(uo0), 0);
    tick();
    rst_n = 1'b1;
    clear_model();
    tick();
    run_drain(0, 0, 0, 0);

    // async reset mid-LOAD_W after a full random load
    for (int r = 0; r < N; r++) begin
      mx[r] = s8($urandom);
      for (int c = 0; c < N; c++) mw[r][c] = s8($urandom);
    end
    send_w(0);
    send_x(0);
    drive(2'd1, 1'b1, 1'b0, 8'h00);
    tick();
    for (int b = 0; b < 5; b++) begin
      drive(2'd0, 1'b1, 1'b0, 8'($urandom));
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rst_loadw_busy", int'(uio_out0[7]), 0);
    tick();
    rst_n = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 8'h00);
    clear_model();
    for (int r = 0; r < N; r++) mx[r] = s8($urandom);
    tick();
    send_x(0);
    run_drain(2, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
